// File: rtl/sgpr_rd_port_arbiter.sv
// Round-robin arbiter sharing one SGPR bank read port among NUM_PORTS requesters.
// Issues a registered grant/read, then returns a per-port data-valid strobe RD_LATENCY cycles later.
module sgpr_rd_port_arbiter #(
    parameter int NUM_PORTS  = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             port_rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_rd_addr,
    output logic [NUM_PORTS-1:0]             port_rd_gnt,
    output logic [NUM_PORTS-1:0]             port_rd_data_valid,
    output logic [DATA_WIDTH-1:0]            port_rd_data,
    output logic                             rd_en,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    output logic [CNT_WIDTH-1:0]             contention_cnt
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PORTS - 1);

    logic [PW-1:0]         r_ptr;
    logic [NUM_PORTS-1:0]  r_gnt;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [NUM_PORTS-1:0]  r_ret [RD_LATENCY];

    logic [NUM_PORTS-1:0]  w_elig;
    logic [PW-1:0]         w_idx;
    logic [PW-1:0]         w_win;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [PW:0]           w_nelig;
    logic                  w_multi;
    logic [PW-1:0]         w_ptr_nxt;
    logic [NUM_PORTS-1:0]  w_gnt_oh;

    // A port whose grant pulse is high this cycle is not eligible again until next cycle.
    assign w_elig = port_rd_req & ~r_gnt;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_addr  = '0;
        w_idx   = r_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
                w_addr  = port_rd_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
            // Explicit wrap so non-power-of-two port counts never visit a missing port.
            if (w_idx == PTR_LAST) w_idx = '0;
            else                   w_idx = w_idx + 1'b1;
        end
    end

    always_comb begin
        w_nelig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_nelig = w_nelig + {{PW{1'b0}}, w_elig[i]};
        end
    end

    assign w_multi   = (w_nelig > (PW+1)'(1));
    assign w_ptr_nxt = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
    assign w_gnt_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_found) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_addr;
                r_gnt     <= w_gnt_oh;
                r_ptr     <= w_ptr_nxt;
            end else begin
                r_rd_en   <= 1'b0;
                r_gnt     <= '0;
            end
            if (w_multi && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Return pipeline: a non-zero one-hot entry doubles as its own valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_ret[s] <= '0;
            end
        end else begin
            r_ret[0] <= r_gnt;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_ret[s] <= r_ret[s-1];
            end
        end
    end

    assign port_rd_gnt        = r_gnt;
    assign port_rd_data_valid = r_ret[RD_LATENCY-1];
    assign port_rd_data       = rd_data;
    assign rd_en              = r_rd_en;
    assign rd_addr            = r_rd_addr;
    assign contention_cnt     = r_cnt;

endmodule

// File: doc/sgpr_rd_port_arbiter.md
Name: sgpr_rd_port_arbiter

Overview:
Parametrised successor to the SGPR read-port multiplexer. It shares one SGPR read port among NUM_PORTS requesters. Simultaneous requests are resolved by registered round-robin arbitration, not treated as illegal. Each request gets a grant pulse and a per-port data-valid strobe aligned to the SGPR read latency. The block sits between the issue, ALU and LSU SGPR readers and the SGPR bank read port.

Parameters:
NUM_PORTS, 8, number of requesting ports (2..16).
ADDR_WIDTH, 9, SGPR address width.
DATA_WIDTH, 32, SGPR read data width.
RD_LATENCY, 1, cycles from rd_en high to rd_data valid at the SGPR bank (1..4).
CNT_WIDTH, 16, width of the contention counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
port_rd_req  in  NUM_PORTS  per-port read request; held high until grant.
port_rd_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]; stable while req high.
port_rd_gnt  out  NUM_PORTS  one-hot, one-cycle grant pulse.
port_rd_data_valid  out  NUM_PORTS  one-hot, one-cycle strobe marking port_rd_data valid for that port.
port_rd_data  out  DATA_WIDTH  broadcast read data; equals rd_data combinationally.
rd_en  out  1  SGPR bank read enable.
rd_addr  out  ADDR_WIDTH  SGPR bank read address.
rd_data  in  DATA_WIDTH  SGPR bank read data, valid RD_LATENCY cycles after rd_en.
contention_cnt  out  CNT_WIDTH  saturating count of cycles with 2 or more eligible requests.

Behaviour:
- Reset (rst=0, asynchronous): rd_en=0, rd_addr=0, port_rd_gnt=0, port_rd_data_valid=0, contention_cnt=0, priority pointer=0 (port 0 highest), return pipeline cleared.
- Eligible request: port_rd_req[i]=1 AND port_rd_gnt[i]=0. A port is never granted in the cycle its grant pulse is high. A single continuously requesting port is therefore served at most every other cycle.
- Arbitration (combinational, from eligible set): search starts at the pointer, ascending, wrapping at NUM_PORTS-1 to 0. The first eligible port wins.
- Registered issue on the rising edge when a winner w exists:
  - rd_en=1 and rd_addr=addr[w].
  - port_rd_gnt=one-hot(w).
  - pointer=(w+1) mod NUM_PORTS.
- With no winner: rd_en=0, rd_gnt=0, rd_addr holds its last value, pointer unchanged.
- Grant latency: a request high at edge k (with no competition) produces gnt/rd_en high in cycle k+1.
- Return pipeline: a RD_LATENCY-deep shift register carries {valid, one-hot w}.
  - port_rd_data_valid[w] is high exactly RD_LATENCY cycles after the cycle rd_en was high for w.
  - In that same cycle rd_data/port_rd_data is valid.
  - Back-to-back issues produce back-to-back strobes in the same order; no reordering.
- Requester protocol: the requester drops req (or presents a new address) in the cycle after it sees gnt. Changing the address while req is high and gnt is low is illegal; the arbiter samples the address only at the grant edge.
- contention_cnt increments each edge where the eligible count is 2 or more. It saturates at all-ones and never wraps.
- Reset mid-operation: in-flight return strobes are discarded. No valid strobe appears after reset release for a read issued before reset.
- NUM_PORTS not a power of two: pointer wrap uses an explicit compare, not truncation.

Test Plan:
1. Single request: port3 req, addr=0x1A5 at edge 0 -> cycle 1: rd_en=1, rd_addr=0x1A5, gnt=0x08. With RD_LATENCY=1, cycle 2: data_valid=0x08 and port_rd_data equals rd_data driven 0xDEADBEEF.
2. All 8 ports request continuously from reset -> grants 0,1,2,...,7 on consecutive cycles, then 0 again. contention_cnt increments every eligible cycle.
3. Ports 2 and 5 request after the pointer reaches 6 -> grant order 2 then 5. Ports 2 and 5 re-requesting -> next order 2,5 (rotating fairness); no port starves.
4. Port 0 alone holding req high indefinitely -> gnt pulses on alternate cycles (0x01,0x00,0x01...). rd_en has the same pattern. contention_cnt stays 0.
5. RD_LATENCY=3, grants to ports 1,4,6 back-to-back -> data_valid 0x02,0x10,0x40 on cycles 3,4,5 after the first rd_en.
6. Assert rst while data_valid is in flight -> all outputs 0 immediately. No data_valid after release. contention_cnt forced to all-ones-1 and two requests for 3 cycles -> holds at all-ones.
